fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage constants: reset PC, bubble encoding, FSM states and
// register-field positions within an instruction word.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  // HOLD parks an accepted word while decode is stalled; DROP waits out a
  // request that a redirect has already made stale.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with bubble (highest priority), load and hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, single-request memory handshake, a
// one-entry stall buffer and redirect handling in front of the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [4:0]  if_rs,
  output logic [4:0]  if_rt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;
  logic [31:0]  redirect_q, redirect_d;

  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr_d;
  logic [31:0]  ifid_pc4_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      redirect_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      redirect_q  <= redirect_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    redirect_d   = redirect_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_instr_d = imem_data;
    ifid_pc4_d   = pc_plus4(pc_q);
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          ifid_bubble = 1'b1;
          if (imem_ready) begin
            pc_d = branch_target;
          end else begin
            // Request still in flight: remember where to go once it retires.
            redirect_d = branch_target;
            state_d    = DROP;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4(pc_q);
          if (stall) begin
            buf_instr_d = imem_data;
            buf_pc4_d   = pc_plus4(pc_q);
            state_d     = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          ifid_bubble = 1'b1;
          pc_d        = branch_target;
          buf_instr_d = 32'd0;
          buf_pc4_d   = 32'd0;
          state_d     = FETCH;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_instr_d = buf_instr_q;
          ifid_pc4_d   = buf_pc4_q;
          state_d      = FETCH;
        end
      end

      DROP: begin
        imem_req    = 1'b1;
        ifid_bubble = 1'b1;
        if (branch_taken) begin
          redirect_d = branch_target;
        end
        if (imem_ready) begin
          pc_d    = branch_taken ? branch_target : redirect_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (rst) begin
      imem_req = 1'b0;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (ifid_bubble),
    .load_i   (ifid_load),
    .instr_i  (ifid_instr_d),
    .pc4_i    (ifid_pc4_d),
    .instr_o  (if_id_instr),
    .pc4_o    (if_id_pc4),
    .valid_o  (if_id_valid)
  );

  assign if_rs = if_id_instr[RS_MSB:RS_LSB];
  assign if_rt = if_id_instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a flag-based
// behavioural model of the fetch pipeline front end.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [4:0]  if_rs;
  logic [4:0]  if_rt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: live PC, "word parked" flag, "in-flight request is
  // stale" flag with its pending target, and the expected IF/ID contents.
  logic [31:0] m_pc    = 32'd0;
  logic        m_held  = 1'b0;
  logic        m_dead  = 1'b0;
  logic [31:0] m_redir = 32'd0;
  logic [31:0] m_buf_i = 32'd0;
  logic [31:0] m_buf_p = 32'd0;
  logic [31:0] m_ii    = 32'd0;
  logic [31:0] m_ip    = 32'd0;
  logic        m_iv    = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .if_rs         (if_rs),
    .if_rt         (if_rt)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'd0) return 32'h2005_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bub();
    m_ii = 32'd0;
    m_ip = 32'd0;
    m_iv = 1'b0;
  endtask

  task automatic compare();
    logic       exp_req;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    exp_req = !rst && !m_held;
    rs_e    = m_ii[25:21];
    rt_e    = m_ii[20:16];
    chk("model_imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("model_imem_addr", imem_addr, m_pc);
    chk("model_if_id_instr", if_id_instr, m_ii);
    chk("model_if_id_pc4", if_id_pc4, m_ip);
    chk("model_if_id_valid", 32'(if_id_valid), 32'(m_iv));
    chk("model_if_rs", 32'(if_rs), 32'(rs_e));
    chk("model_if_rt", 32'(if_rt), 32'(rt_e));
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = 32'd0; m_held = 1'b0; m_dead = 1'b0; m_redir = 32'd0;
      m_buf_i = 32'd0; m_buf_p = 32'd0;
      bub();
    end else if (m_held) begin
      if (branch_taken) begin
        m_held = 1'b0;
        m_pc   = branch_target;
        bub();
      end else if (!stall) begin
        m_ii = m_buf_i; m_ip = m_buf_p; m_iv = 1'b1;
        m_held = 1'b0;
      end
    end else if (m_dead) begin
      if (branch_taken) m_redir = branch_target;
      bub();
      if (imem_ready) begin
        m_pc   = m_redir;
        m_dead = 1'b0;
      end
    end else begin
      if (branch_taken) begin
        bub();
        if (imem_ready) m_pc = branch_target;
        else begin
          m_dead  = 1'b1;
          m_redir = branch_target;
        end
      end else if (imem_ready) begin
        if (stall) begin
          m_buf_i = imem_data; m_buf_p = m_pc + 32'd4; m_held = 1'b1;
        end else begin
          m_ii = imem_data; m_ip = m_pc + 32'd4; m_iv = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        bub();
      end
    end
  endtask

  // One clock: drive at negedge, compare against model, advance the model
  // across the following rising edge.
  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [31:0] t, input logic rdy);
    @(negedge clk);
    rst           = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    imem_ready    = rdy;
    imem_data     = rdy ? memfn(m_pc) : $urandom;
    #1;
    compare();
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r, s, b, rdy;
    logic [31:0] t;

    // Reset, then zero-wait fetch of 32'h2005_0005 at address 0
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    chk("rst_if_rs", 32'(if_rs), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    settle();
    chk("first_instr", if_id_instr, 32'h2005_0005);
    chk("first_pc4", if_id_pc4, 32'd4);
    chk("first_rs", 32'(if_rs), 32'd0);
    chk("first_rt", 32'(if_rt), 32'd5);
    chk("first_next_addr", imem_addr, 32'd4);

    // Stall 3 cycles while the word for pc=8 arrives
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    settle();
    chk("hold_imem_req", 32'(imem_req), 32'd0);
    chk("hold_pc4_kept", if_id_pc4, 32'd8);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    settle();
    chk("hold_pc4_kept3", if_id_pc4, 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    settle();
    chk("unhold_instr", if_id_instr, memfn(32'd8));
    chk("unhold_pc4", if_id_pc4, 32'd12);
    chk("unhold_next_addr", imem_addr, 32'd12);
    chk("unhold_req", 32'(imem_req), 32'd1);

    // Redirect to 0x40 during a 2-cycle-wait request at pc=16
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    settle();
    chk("drop_addr_held", imem_addr, 32'd16);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_valid", 32'(if_id_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    settle();
    chk("drop_next_addr", imem_addr, 32'h40);
    chk("drop_valid2", 32'(if_id_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    settle();
    chk("target_pc4", if_id_pc4, 32'h44);

    // Branch and stall together while HOLD
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    settle();
    chk("holdbr_valid", 32'(if_id_valid), 32'd0);
    chk("holdbr_addr", imem_addr, 32'h100);
    chk("holdbr_req", 32'(imem_req), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    settle();
    chk("holdbr_pc4", if_id_pc4, 32'h104);

    // Reset with a response arriving during reset
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    settle();
    chk("rst2_req", 32'(imem_req), 32'd0);
    chk("rst2_valid", 32'(if_id_valid), 32'd0);
    chk("rst2_instr", if_id_instr, 32'd0);
    chk("rst2_pc4", if_id_pc4, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    settle();
    chk("rst2_first_addr", imem_addr, 32'd0);
    chk("rst2_first_req", 32'(imem_req), 32'd1);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    settle();
    chk("wrap_pc4", if_id_pc4, 32'd0);
    chk("wrap_valid", 32'(if_id_valid), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 7) == 0);
      t   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rdy = ($urandom_range(0, 2) != 0) && (!m_held || ($urandom_range(0, 9) == 0));
      cyc(r, s, b, t, rdy);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
